// File: rtl/arb_pkg.sv
// Shared types for the two-requester decoder arbiter: FSM state encoding and
// the tie-break rule used whenever the arbiter picks a new owner.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  // Winner index given both requests and the last owner; only meaningful
  // when at least one request is high. A tie goes to whoever did not own last.
  function automatic logic pick_winner(input logic req0, input logic req1,
                                       input logic last);
    return (req0 && req1) ? ~last : req1;
  endfunction

endpackage

// File: rtl/decoder_1x2.sv
// One-to-two line decoder: turns the owner index into one-hot select lines.
module decoder_1x2 (
  input  logic sel_i,
  output logic y0_o,
  output logic y1_o
);

  assign y0_o = ~sel_i;
  assign y1_o =  sel_i;

endmodule

// File: rtl/decoder_arbiter_2.sv
// Two-requester arbiter with bounded hold under contention and a one-cycle
// break-before-make gap on every handover; grants come from decoding sel.
module decoder_arbiter_2
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1,
  output logic sel,
  output logic busy
);

  localparam int unsigned       HOLD_W   = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q,  last_d;
  logic [HOLD_W-1:0] hold_q,  hold_d;
  logic [1:0]        req;
  logic              y0, y1;

  assign req = {req1, req0};

  // NOTE: every next-state signal takes its current value first, so no path
  // through the case statement leaves one unassigned and no latch appears.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = hold_q;
    case (state_q)
      OWN: begin
        if (!req[owner_q] || (req[~owner_q] && hold_q == HOLD_MAX)) begin
          state_d = GAP;
          last_d  = owner_q;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + HOLD_ONE;
        end
      end
      default: begin
        // IDLE and GAP arbitrate identically; GAP just never repeats itself.
        if (req0 || req1) begin
          state_d = OWN;
          owner_d = pick_winner(req0, req1, last_q);
          hold_d  = HOLD_ONE;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; the asynchronous clear drops grants without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  assign sel  = owner_q;
  assign busy = (state_q == OWN);

  decoder_1x2 u_decoder (
    .sel_i (owner_q),
    .y0_o  (y0),
    .y1_o  (y1)
  );

  assign gnt0 = busy & y0;
  assign gnt1 = busy & y1;

  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    !(gnt0 && gnt1));
  a_busy_match: assert property (@(posedge clk) disable iff (!rst_n)
    busy == (gnt0 || gnt1));
  a_hold_bound: assert property (@(posedge clk) disable iff (!rst_n)
    hold_q <= HOLD_MAX);

endmodule
